// File: rtl/booth_sched.sv
// Control FSM that schedules two requesters onto one shared Booth multiplier datapath.
// It arbitrates round-robin, then sequences LOAD, N x (ADD, SHIFT) and DONE for the winner.
module booth_sched #(
    parameter int N = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       q0,
    input  logic       q_menos1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       sel,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic       Carga_A,
    output logic       Carga_QM,
    output logic       Desplaza_AQ,
    output logic       Reset_A,
    output logic       Resta,
    output logic [2:0] state_dbg
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_next;
    logic          owner, owner_next;
    logic          last, last_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          winner;

    // Handshake: reqX is a level request sampled only in IDLE; gntX stays high from LOAD
    // through DONE for the owner, doneX pulses once in DONE, and req changes in between are ignored.
    always_comb begin
        winner = (req0 && req1) ? ~last : req1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last  <= last_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = LOAD;
                    owner_next = winner;
                    last_next  = winner;
                end
            end
            LOAD: begin
                state_next = ADD;
                cnt_next   = '0;
            end
            ADD: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                cnt_next   = cnt + CW'(1);
                state_next = (cnt == CW'(N - 1)) ? DONE : ADD;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; q bits qualify the ADD strobes.
    always_comb begin
        busy        = (state != IDLE);
        gnt0        = busy && !owner;
        gnt1        = busy && owner;
        sel         = busy && owner;
        done0       = (state == DONE) && !owner;
        done1       = (state == DONE) && owner;
        Carga_QM    = (state == LOAD);
        Reset_A     = (state == LOAD);
        Carga_A     = (state == ADD) && (q0 ^ q_menos1);
        Resta       = (state == ADD) && q0 && !q_menos1;
        Desplaza_AQ = (state == SHIFT);
        state_dbg   = state;
    end

endmodule

// File: tb/tb_booth_sched.sv
// Bench for booth_sched: cycle-exact output checks per scenario plus an owner scoreboard
// filled when requests are driven and drained on each done pulse.
module tb_booth_sched;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       q0 = 1'b0;
    logic       q_menos1 = 1'b0;
    logic       gnt0, gnt1, sel, done0, done1, busy;
    logic       Carga_A, Carga_QM, Desplaza_AQ, Reset_A, Resta;
    logic [2:0] state_dbg;

    logic [0:0] exp_q[$];
    logic       model_last;
    int         total = 0;
    int         bad = 0;

    booth_sched #(.N(N)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .q0(q0), .q_menos1(q_menos1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .done0(done0), .done1(done1),
        .busy(busy), .Carga_A(Carga_A), .Carga_QM(Carga_QM),
        .Desplaza_AQ(Desplaza_AQ), .Reset_A(Reset_A), .Resta(Resta),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {gnt0,gnt1,sel,busy,done0,done1,Carga_QM,Reset_A,Carga_A,Resta,Desplaza_AQ}
    wire [10:0] outs = {gnt0, gnt1, sel, busy, done0, done1,
                        Carga_QM, Reset_A, Carga_A, Resta, Desplaza_AQ};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request pattern and record the owner the round-robin model predicts.
    task automatic issue(input logic r0, input logic r1, output logic w);
        req0 = r0;
        req1 = r1;
        w = (r0 && r1) ? ~model_last : r1;
        model_last = w;
        exp_q.push_back(w);
    endtask

    // Called with the DUT just observed in LOAD; walks the whole operation to the IDLE after DONE.
    task automatic run_op(input logic o, input bit handoff, input int base);
        logic [10:0] exp;
        logic [1:0]  pat;
        logic        e;
        exp = {~o, o, o, 1'b1, 2'b00, 1'b1, 1'b1, 3'b000};
        total++;
        if (outs !== exp) begin
            bad++;
            $display("FAIL load: got %b want %b", outs, exp);
        end
        for (int it = 0; it < N; it++) begin
            tick();
            pat = 2'((base + it) % 4);
            q0 = pat[1];
            q_menos1 = pat[0];
            #1;
            exp = {~o, o, o, 1'b1, 2'b00, 2'b00, q0 ^ q_menos1, q0 & ~q_menos1, 1'b0};
            total++;
            if (outs !== exp) begin
                bad++;
                $display("FAIL add it=%0d q=%b: got %b want %b", it, pat, outs, exp);
            end
            tick();
            exp = {~o, o, o, 1'b1, 2'b00, 2'b00, 3'b001};
            total++;
            if (outs !== exp) begin
                bad++;
                $display("FAIL shift it=%0d: got %b want %b", it, outs, exp);
            end
            if (handoff && it == 0) begin
                req0 = 1'b0;
                req1 = 1'b1;
            end
        end
        tick();
        exp = {~o, o, o, 1'b1, ~o, o, 5'b00000};
        total++;
        if (outs !== exp) begin
            bad++;
            $display("FAIL done: got %b want %b", outs, exp);
        end
        if (done0 || done1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: got done1=%b want no done", done1);
            end else begin
                e = exp_q.pop_front();
                if (done1 !== e) begin
                    bad++;
                    $display("FAIL sb_owner: got done1=%b want %b", done1, e);
                end
            end
        end
        tick();
        exp = '0;
        total++;
        if (outs !== exp) begin
            bad++;
            $display("FAIL idle_after: got %b want %b", outs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        total++;
        if (outs !== 11'd0) begin
            bad++;
            $display("FAIL reset_outs: got %b want 0", outs);
        end
        reset = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic test_reset();
        logic w;
        reset = 1'b0;
        req0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (outs !== 11'd0) begin
                bad++;
                $display("FAIL reset_hold%0d: got %b want 0", i, outs);
            end
        end
        reset = 1'b1;
        model_last = 1'b1;
        issue(1'b1, 1'b0, w);
        tick();
        req0 = 1'b0;
        run_op(w, 1'b0, 1);
    endtask

    task automatic test_booth_decode();
        logic w;
        logic r;
        for (int op = 0; op < 4; op++) begin
            r = 1'($urandom_range(0, 1));
            issue(~r, r, w);
            tick();
            req0 = 1'b0;
            req1 = 1'b0;
            run_op(w, 1'b0, op);
        end
    endtask

    task automatic test_back_to_back();
        logic w;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 1'b1, w);
            tick();
            run_op(w, 1'b0, $urandom_range(0, 3));
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic w;
        logic [10:0] exp;
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        for (int c = 2; c <= 5; c++) tick();
        exp = {3'b100, 1'b1, 2'b00, 2'b00, 3'b001};
        total++;
        if (outs !== exp) begin
            bad++;
            $display("FAIL mid_shift2: got %b want %b", outs, exp);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (outs !== 11'd0) begin
                bad++;
                $display("FAIL mid_reset%0d: got %b want 0", i, outs);
            end
        end
        reset = 1'b1;
        model_last = 1'b1;
        issue(1'b1, 1'b1, w);
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        run_op(w, 1'b0, 2);
    endtask

    task automatic test_handoff();
        logic w;
        issue(1'b1, 1'b0, w);
        tick();
        run_op(w, 1'b1, 3);
        issue(1'b0, 1'b1, w);
        tick();
        req1 = 1'b0;
        run_op(w, 1'b0, 0);
    endtask

    initial begin
        model_last = 1'b1;
        test_reset();
        test_booth_decode();
        test_back_to_back();
        test_mid_reset();
        test_handoff();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
